nvdla_tcdm_responder: RTL and testbench
=======================================

Name: nvdla_tcdm_responder

Overview:
- Multi-port TCDM slave that answers the TCDM master ports driven by the NVDLA streamer: DBB load, DBB store and CSB store.
- Round-robin arbitrates the NP request ports onto one word-addressed memory bank.
- Returns read data through a fixed-latency response pipeline.
- Used as the memory endpoint in the standalone HWPE testbench and as a small scratch bank in integration.

Parameters:
- NP, 3: number of TCDM slave ports.
- MEM_WORDS, 1024: memory depth in 32-bit words; must be a power of 2.
- LAT, 1: read latency in cycles from grant to r_valid; legal range 1..4.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- tcdm_req_i  in  NP  per-port request.
- tcdm_gnt_o  out  NP  per-port grant; combinational, at most one bit high.
- tcdm_add_i  in  NP x 32  byte address per port.
- tcdm_wen_i  in  NP  per-port write enable, active-low: 0 = write, 1 = read.
- tcdm_be_i  in  NP x 4  per-port byte enables, writes only.
- tcdm_data_i  in  NP x 32  write data.
- tcdm_r_data_o  out  NP x 32  read data.
- tcdm_r_valid_o  out  NP  read-data valid; one-cycle pulse per granted read.

Behaviour:
- Reset:
  - tcdm_r_valid_o=0 and tcdm_r_data_o=0 on all ports; response pipeline cleared.
  - RR pointer=0; LFSR loaded with seed (optional feature).
  - tcdm_gnt_o forced 0 while rst_ni=0.
  - Memory contents not reset.
- Addressing: word index = add[2+log2(MEM_WORDS)-1 : 2]. Upper bits and add[1:0] ignored; out-of-range addresses alias (wrap) and never error.
- Arbitration:
  - Each cycle, grant the first requesting port at or after the RR pointer, searching upward with wrap.
  - On a grant to port k, the pointer becomes (k+1) mod NP. No grant leaves the pointer unchanged.
  - Throughput: one access per cycle.
  - Grant is combinational from req in the same cycle. A requester must hold req/add/wen/be/data stable until granted.
- Write (wen=0), when granted: in the same clock edge, update memory bytes whose be bit is set; other bytes unchanged. No response is generated.
- Read (wen=1), when granted:
  - The memory word is sampled at the grant edge and enters a LAT-deep pipeline carrying {valid, port id, data}.
  - tcdm_r_valid_o[id] pulses exactly LAT cycles after the grant cycle, with the data on tcdm_r_data_o[id].
  - Other ports' r_data hold their last value.
- Ordering:
  - A write granted in cycle t is visible to a read granted in cycle t+1 or later.
  - A read and a write cannot coincide because there is one grant per cycle.
- Back-to-back reads: with LAT>1 there can be LAT reads in flight. Responses return in grant order, one per cycle, with no bubbles.
- Same port re-granted on consecutive cycles is legal; r_valid stays high on consecutive cycles.
- Reset mid-operation: all in-flight responses are dropped and no r_valid is emitted afterward. Writes already granted before reset remain in memory.
- Idle (no req): no grant, the pipeline drains normally, and the pointer is held.

Optional Feature:
- NVDLA_TCDM_RESP_STALL_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every cycle.
  - When lfsr[1:0]==2'b00, all grants are suppressed that cycle and the RR pointer is held.
  - This exercises the requesters' gnt-stall handling.
- Undefined: grant is given whenever any req is high; no LFSR logic.

Test Plan:
- Write then read, port 0, LAT=1: write add=0x40, data=0xDEADBEEF, be=4'hF; then read add=0x40 → gnt same cycle each time; r_valid[0] one cycle after the read grant with r_data=0xDEADBEEF.
- Round-robin, NP=3: all three ports hold reads to 0x0/0x4/0x8 from reset → grants in order port0, port1, port2 over three consecutive cycles. r_valid pulses on ports 0, 1, 2 in the following three cycles with matching data.
- Byte enables: preload 0x11223344 at 0x10; write 0xAABBCCDD with be=4'b0101; read → 0x11BB33DD.
- Pipelined latency, LAT=3: port 1 issues 4 back-to-back reads of 0x0..0xC → r_valid[1] high for 4 consecutive cycles starting 3 cycles after the first grant, data in address order.
- Aliasing plus reset: MEM_WORDS=1024; write 0x5A5A5A5A to 0x1000, read 0x0 → 0x5A5A5A5A. Then issue a read and assert rst_ni=0 before its response is due → r_valid never asserts, and outputs are 0 after reset.
- Stall feature (macro defined): port 0 requests continuously for 64 cycles → gnt low exactly on cycles where lfsr[1:0]==0 per the reference LFSR model. The count of granted cycles matches the model, and every granted read returns data.

Source files
------------

// File: rtl/nvdla_tcdm_responder_if.sv
// TCDM port bundle between the NVDLA streamer masters and nvdla_tcdm_responder.
// One request lane per slave port; signal names follow the port naming of the responder.
interface nvdla_tcdm_responder_if #(
  parameter int NP = 3
);
  logic [NP-1:0]        tcdm_req_i;
  logic [NP-1:0]        tcdm_gnt_o;
  logic [NP-1:0][31:0]  tcdm_add_i;
  logic [NP-1:0]        tcdm_wen_i;
  logic [NP-1:0][3:0]   tcdm_be_i;
  logic [NP-1:0][31:0]  tcdm_data_i;
  logic [NP-1:0][31:0]  tcdm_r_data_o;
  logic [NP-1:0]        tcdm_r_valid_o;

  modport slave (
    input  tcdm_req_i, tcdm_add_i, tcdm_wen_i, tcdm_be_i, tcdm_data_i,
    output tcdm_gnt_o, tcdm_r_data_o, tcdm_r_valid_o
  );

  modport master (
    output tcdm_req_i, tcdm_add_i, tcdm_wen_i, tcdm_be_i, tcdm_data_i,
    input  tcdm_gnt_o, tcdm_r_data_o, tcdm_r_valid_o
  );
endinterface

// File: rtl/nvdla_tcdm_responder.sv
// Multi-port TCDM slave: round-robin arbitration onto one word-addressed bank, fixed-latency reads.
// Optional random grant stalls via an LFSR when NVDLA_TCDM_RESP_STALL_EN is defined.
module nvdla_tcdm_responder #(
  parameter int NP        = 3,
  parameter int MEM_WORDS = 1024,
  parameter int LAT       = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  nvdla_tcdm_responder_if.slave tcdm
);
  localparam int AW  = $clog2(MEM_WORDS);
  localparam int IDW = (NP > 1) ? $clog2(NP) : 1;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
    logic [31:0]    data;
  } rsp_t;

  logic [31:0]         mem_q [MEM_WORDS];
  logic [IDW-1:0]      ptr_q, ptr_d;
  rsp_t                pipe_q [LAT];
  logic [NP-1:0][31:0] r_data_q;
  logic [NP-1:0]       gnt_vec;
  logic [IDW-1:0]      gnt_id, cand;
  logic                gnt_any, stall;
  logic [AW-1:0]       word_idx;
  logic [NP-1:0]       r_valid;
  logic [NP-1:0][31:0] r_data;
  logic                unused_add_bits;

`ifdef NVDLA_TCDM_RESP_STALL_EN
  logic [15:0] lfsr_q;

  // Fibonacci taps 16,14,13,11 in right-shift form feed back bits 0,2,3,5.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) lfsr_q <= 16'hACE1;
    else         lfsr_q <= {^(lfsr_q & 16'h002D), lfsr_q[15:1]};
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    gnt_vec = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int i = 0; i < NP; i++) begin
      cand = IDW'((int'(ptr_q) + i) % NP);
      if (!gnt_any && tcdm.tcdm_req_i[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
    end
    if (!rst_ni || stall) gnt_any = 1'b0;
    if (gnt_any) gnt_vec[gnt_id] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_id == IDW'(NP - 1)) ? '0 : gnt_id + 1'b1;
  end

  assign tcdm.tcdm_gnt_o = gnt_vec;
  assign word_idx        = tcdm.tcdm_add_i[gnt_id][AW+1:2];
  assign unused_add_bits = ^tcdm.tcdm_add_i;

  // Bank contents survive reset; gnt_any is already low while rst_ni is low.
  always_ff @(posedge clk_i) begin
    if (gnt_any && !tcdm.tcdm_wen_i[gnt_id]) begin
      for (int b = 0; b < 4; b++) begin
        if (tcdm.tcdm_be_i[gnt_id][b])
          mem_q[word_idx][8*b +: 8] <= tcdm.tcdm_data_i[gnt_id][8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q    <= '0;
      r_data_q <= '0;
      for (int s = 0; s < LAT; s++) pipe_q[s] <= '0;
    end else begin
      ptr_q           <= ptr_d;
      pipe_q[0].valid <= gnt_any && tcdm.tcdm_wen_i[gnt_id];
      pipe_q[0].id    <= gnt_id;
      pipe_q[0].data  <= mem_q[word_idx];
      for (int s = 1; s < LAT; s++) pipe_q[s] <= pipe_q[s-1];
      if (pipe_q[LAT-1].valid) r_data_q[pipe_q[LAT-1].id] <= pipe_q[LAT-1].data;
    end
  end

  // Last stage drives the pulse; r_data_q keeps each port's last word between pulses.
  always_comb begin
    r_valid = '0;
    r_data  = r_data_q;
    if (pipe_q[LAT-1].valid) begin
      r_valid[pipe_q[LAT-1].id] = 1'b1;
      r_data[pipe_q[LAT-1].id]  = pipe_q[LAT-1].data;
    end
  end

  assign tcdm.tcdm_r_valid_o = r_valid;
  assign tcdm.tcdm_r_data_o  = r_data;
endmodule

// File: tb/tb_nvdla_tcdm_responder.sv
// Bench for nvdla_tcdm_responder: two instances (LAT=1 and LAT=3) share one stimulus
// and are compared every cycle against a behavioural memory/arbiter model.
module tb_nvdla_tcdm_responder;
  localparam int NP        = 3;
  localparam int MEM_WORDS = 1024;
  localparam int LAT_A     = 1;
  localparam int LAT_B     = 3;
  localparam logic [31:0] V [4] = '{32'h0000_1111, 32'h2222_0000, 32'h3333_4444, 32'h5555_6666};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]       req, wen;
  logic [NP-1:0][31:0] add, wdata;
  logic [NP-1:0][3:0]  be;

  nvdla_tcdm_responder_if #(.NP(NP)) bus_a ();
  nvdla_tcdm_responder_if #(.NP(NP)) bus_b ();

  assign bus_a.tcdm_req_i  = req;
  assign bus_a.tcdm_add_i  = add;
  assign bus_a.tcdm_wen_i  = wen;
  assign bus_a.tcdm_be_i   = be;
  assign bus_a.tcdm_data_i = wdata;
  assign bus_b.tcdm_req_i  = req;
  assign bus_b.tcdm_add_i  = add;
  assign bus_b.tcdm_wen_i  = wen;
  assign bus_b.tcdm_be_i   = be;
  assign bus_b.tcdm_data_i = wdata;

  nvdla_tcdm_responder #(.NP(NP), .MEM_WORDS(MEM_WORDS), .LAT(LAT_A)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .tcdm(bus_a.slave));
  nvdla_tcdm_responder #(.NP(NP), .MEM_WORDS(MEM_WORDS), .LAT(LAT_B)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .tcdm(bus_b.slave));

  logic [NP-1:0]       gnt [2];
  logic [NP-1:0]       rv  [2];
  logic [NP-1:0][31:0] rd  [2];
  assign gnt[0] = bus_a.tcdm_gnt_o;
  assign gnt[1] = bus_b.tcdm_gnt_o;
  assign rv[0]  = bus_a.tcdm_r_valid_o;
  assign rv[1]  = bus_b.tcdm_r_valid_o;
  assign rd[0]  = bus_a.tcdm_r_data_o;
  assign rd[1]  = bus_b.tcdm_r_data_o;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
    bit          known;
  } exp_rsp_t;

  logic [31:0] m_mem   [MEM_WORDS];
  bit          m_known [MEM_WORDS];
  int          m_ptr;
  logic [15:0] m_lfsr;
  bit          model_ok = 1'b0;
  int          cyc = 0;
  int          m_gcount = 0;
  exp_rsp_t    rq [2][$];
  logic [31:0] ld  [2][NP];
  bit          ldk [2][NP];

  logic [31:0] cap  [2*NP][$];
  int          capc [2*NP][$];
  int          glog [$];
  int          glog_cyc [$];

  function automatic int lat_of(int d);
    return (d == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic logic [15:0] lfsr_next(logic [15:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return (v >> 1) | (16'(fb) << 15);
  endfunction

  function automatic bit model_stall();
`ifdef NVDLA_TCDM_RESP_STALL_EN
    return (m_lfsr % 4) == 0;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin : model_chk
    int exp_k, p, w;
    logic [NP-1:0] exp_g, exp_rv;
    logic [31:0] mask;
    exp_k = -1;
    for (int d = 0; d < 2; d++)
      for (int q = 0; q < NP; q++)
        if (rv[d][q] === 1'b1) begin
          cap[d*NP+q].push_back(rd[d][q]);
          capc[d*NP+q].push_back(cyc);
        end
    for (int q = 0; q < NP; q++)
      if (gnt[0][q] === 1'b1) begin
        glog.push_back(q);
        glog_cyc.push_back(cyc);
      end
    if (model_ok) begin
      if (rst_n && !model_stall())
        for (int i = 0; i < NP; i++) begin
          p = (m_ptr + i) % NP;
          if (exp_k < 0 && req[p]) exp_k = p;
        end
      exp_g = '0;
      if (exp_k >= 0) exp_g[exp_k] = 1'b1;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("gnt dut%0d", d), 32'(gnt[d]), 32'(exp_g));
        exp_rv = '0;
        if (rq[d].size() > 0 && rq[d][0].due == cyc) exp_rv[rq[d][0].port] = 1'b1;
        chk($sformatf("r_valid dut%0d", d), 32'(rv[d]), 32'(exp_rv));
        for (int q = 0; q < NP; q++) begin
          if (exp_rv[q]) begin
            if (rq[d][0].known) chk($sformatf("r_data dut%0d p%0d", d, q), rd[d][q], rq[d][0].data);
          end else if (ldk[d][q]) begin
            chk($sformatf("r_data_hold dut%0d p%0d", d, q), rd[d][q], ld[d][q]);
          end
        end
        if (exp_rv != '0) begin
          ld[d][rq[d][0].port]  = rq[d][0].data;
          ldk[d][rq[d][0].port] = rq[d][0].known;
          void'(rq[d].pop_front());
        end
      end
    end
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        rq[d].delete();
        for (int q = 0; q < NP; q++) begin
          ld[d][q]  = '0;
          ldk[d][q] = 1'b1;
        end
      end
      m_ptr    = 0;
      m_lfsr   = 16'hACE1;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (exp_k >= 0) begin
        m_gcount++;
        w = int'((add[exp_k] >> 2) % MEM_WORDS);
        if (!wen[exp_k]) begin
          mask = {{8{be[exp_k][3]}}, {8{be[exp_k][2]}}, {8{be[exp_k][1]}}, {8{be[exp_k][0]}}};
          m_mem[w]   = (m_mem[w] & ~mask) | (wdata[exp_k] & mask);
          m_known[w] = m_known[w] || (be[exp_k] == 4'hF);
        end else begin
          for (int d = 0; d < 2; d++)
            rq[d].push_back('{due: cyc + lat_of(d), port: exp_k, data: m_mem[w], known: m_known[w]});
        end
        m_ptr = (exp_k + 1) % NP;
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  typedef struct {
    logic        wen;
    logic [31:0] add;
    logic [3:0]  be;
    logic [31:0] data;
  } req_t;

  req_t pq [NP][$];

  task automatic push_req(int p, logic w, logic [31:0] a, logic [3:0] b, logic [31:0] d);
    pq[p].push_back('{wen: w, add: a, be: b, data: d});
  endtask

  // Presents each port's queued requests in order, holding each until granted.
  task automatic run_queues();
    bit done_last [NP];
    bit busy;
    int budget;
    budget = 500;
    for (int p = 0; p < NP; p++) done_last[p] = 1'b0;
    forever begin
      @(posedge clk); #1;
      busy = 1'b0;
      for (int p = 0; p < NP; p++) begin
        if (done_last[p]) void'(pq[p].pop_front());
        if (pq[p].size() > 0) begin
          req[p]   = 1'b1;
          wen[p]   = pq[p][0].wen;
          add[p]   = pq[p][0].add;
          be[p]    = pq[p][0].be;
          wdata[p] = pq[p][0].data;
          busy     = 1'b1;
        end else begin
          req[p] = 1'b0;
        end
      end
      if (!busy) break;
      @(negedge clk);
      for (int p = 0; p < NP; p++) done_last[p] = gnt[0][p];
      budget--;
      if (budget == 0) begin
        chk("run_queues timeout", 32'(busy), 32'd0);
        for (int p = 0; p < NP; p++) pq[p].delete();
        req = '0;
        break;
      end
    end
  endtask

  task automatic drain(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] last_cap(int idx);
    if (cap[idx].size() == 0) return 32'hBAD0_BAD0;
    return cap[idx][cap[idx].size()-1];
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int sa, sb, n, g0, got;
    req = '0; wen = '1; add = '0; wdata = '0; be = '0;

    // reset: requests are ignored and outputs are zero
    rst_n  = 1'b0;
    req[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset gnt", 32'(gnt[0]), 32'd0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset r_valid dut%0d", d), 32'(rv[d]), 32'd0);
      for (int q = 0; q < NP; q++) chk($sformatf("reset r_data dut%0d p%0d", d, q), rd[d][q], 32'd0);
    end
    @(posedge clk); #1;
    req   = '0;
    rst_n = 1'b1;

    // write then read, port 0
    push_req(0, 1'b0, 32'h40, 4'hF, 32'hDEAD_BEEF);
    push_req(0, 1'b1, 32'h40, 4'h0, 32'h0);
    run_queues();
    drain(6);
    chk("wr/rd data lat1", last_cap(0), 32'hDEAD_BEEF);
    chk("wr/rd data lat3", last_cap(NP), 32'hDEAD_BEEF);
    chk("lat1 delay", 32'(capc[0][capc[0].size()-1] - glog_cyc[glog_cyc.size()-1]), 32'd1);

    // preload 0x0..0xC through port 2, then round-robin reads from all ports
    for (int i = 0; i < 4; i++) push_req(2, 1'b0, 32'(4*i), 4'hF, V[i]);
    run_queues();
    glog.delete(); glog_cyc.delete();
    push_req(0, 1'b1, 32'h0, 4'h0, 32'h0);
    push_req(1, 1'b1, 32'h4, 4'h0, 32'h0);
    push_req(2, 1'b1, 32'h8, 4'h0, 32'h0);
    run_queues();
    drain(6);
    chk("rr grant count", 32'(glog.size()), 32'd3);
    for (int i = 0; i < 3 && i < glog.size(); i++) chk($sformatf("rr order %0d", i), 32'(glog[i]), 32'(i));
`ifndef NVDLA_TCDM_RESP_STALL_EN
    chk("rr consecutive", 32'(glog_cyc[2] - glog_cyc[0]), 32'd2);
`endif
    for (int q = 0; q < 3; q++) begin
      chk($sformatf("rr data lat1 p%0d", q), last_cap(q), V[q]);
      chk($sformatf("rr data lat3 p%0d", q), last_cap(NP + q), V[q]);
    end

    // byte enables
    push_req(0, 1'b0, 32'h10, 4'hF, 32'h1122_3344);
    push_req(0, 1'b0, 32'h10, 4'b0101, 32'hAABB_CCDD);
    push_req(0, 1'b1, 32'h10, 4'h0, 32'h0);
    run_queues();
    drain(6);
    chk("byte enable lat1", last_cap(0), 32'h11BB_33DD);
    chk("byte enable lat3", last_cap(NP), 32'h11BB_33DD);

    // four back-to-back reads on port 1
    sb = cap[NP+1].size();
    glog.delete(); glog_cyc.delete();
    for (int i = 0; i < 4; i++) push_req(1, 1'b1, 32'(4*i), 4'h0, 32'h0);
    run_queues();
    drain(8);
    chk("pipelined count", 32'(cap[NP+1].size() - sb), 32'd4);
    if (cap[NP+1].size() - sb == 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("pipelined data %0d", i), cap[NP+1][sb+i], V[i]);
`ifndef NVDLA_TCDM_RESP_STALL_EN
      chk("pipelined first delay", 32'(capc[NP+1][sb] - glog_cyc[0]), 32'd3);
      chk("pipelined no bubbles", 32'(capc[NP+1][sb+3] - capc[NP+1][sb]), 32'd3);
`endif
    end

    // address aliasing and ignored low/high bits
    push_req(0, 1'b0, 32'h1000, 4'hF, 32'h5A5A_5A5A);
    push_req(0, 1'b1, 32'h0, 4'h0, 32'h0);
    push_req(0, 1'b1, 32'hFFF0_1004, 4'h0, 32'h0);
    push_req(0, 1'b1, 32'h43, 4'h0, 32'h0);
    run_queues();
    drain(6);
    n = cap[0].size();
    chk("alias 0x1000->0x0", cap[0][n-3], 32'h5A5A_5A5A);
    chk("alias high bits", cap[0][n-2], V[1]);
    chk("alias low bits", cap[0][n-1], 32'hDEAD_BEEF);

    // reset while a read is in flight
    sa = cap[1].size();
    sb = cap[NP+1].size();
    @(posedge clk); #1;
    req[1] = 1'b1; wen[1] = 1'b1; add[1] = 32'h8;
    got = 0;
    for (int i = 0; i < 50 && got == 0; i++) begin
      @(negedge clk);
      got = int'(gnt[0][1]);
    end
    chk("mid-reset read granted", 32'(got), 32'd1);
    @(posedge clk); #1;
    req   = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int q = 0; q < NP; q++) chk($sformatf("in reset r_data lat3 p%0d", q), rd[1][q], 32'd0);
    chk("in reset r_valid lat3", 32'(rv[1]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drain(6);
    chk("dropped response lat3", 32'(cap[NP+1].size() - sb), 32'd0);
    chk("pre-reset response lat1", 32'(cap[1].size() - sa), 32'd1);
    push_req(2, 1'b1, 32'h40, 4'h0, 32'h0);
    run_queues();
    drain(6);
    chk("memory kept over reset", last_cap(NP + 2), 32'hDEAD_BEEF);

    // continuous requests on port 0 for 64 cycles
    sa = cap[0].size();
    sb = cap[NP].size();
    @(posedge clk); #1;
    g0 = m_gcount;
    req[0] = 1'b1; wen[0] = 1'b1; add[0] = 32'h4;
    n = 0;
    repeat (64) begin
      @(negedge clk);
      n += int'(gnt[0][0]);
    end
    @(posedge clk); #1;
    req = '0;
    chk("stream grant count vs model", 32'(n), 32'(m_gcount - g0));
`ifndef NVDLA_TCDM_RESP_STALL_EN
    chk("stream grant count", 32'(n), 32'd64);
`endif
    drain(6);
    chk("stream responses lat1", 32'(cap[0].size() - sa), 32'(n));
    chk("stream responses lat3", 32'(cap[NP].size() - sb), 32'(n));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
